altusoc_tcm_loader: RTL and testbench
=====================================

Name: altusoc_tcm_loader

Overview:
- Synthesizable boot-image loader and run watchdog for the AltuSOC.
- Copies a runtime-selected number of words from a synchronous boot ROM into the TCM write port, holding the core in reset until the copy completes.
- After release, runs a cycle watchdog that flags a hang.
- Replaces the testbench-only preload loop and the fixed cycle-timeout monitor with parametrised hardware usable on silicon and in simulation.

Parameters:
- DATA_W, 32: word width of the ROM and TCM data paths.
- DEPTH, 16384: TCM depth in words; AW = $clog2(DEPTH).
- CNT_W, 32: watchdog counter width.
- TIMEOUT_CYCLES, 100000: watchdog limit; 0 disables the watchdog.
- HALT_ON_TIMEOUT, 1: if 1, the core is re-held in reset on timeout.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: asynchronous active-low reset.
- i_start, in, 1: one-cycle load request.
- i_load_words, in, AW+1: number of words to copy; sampled on accepted i_start.
- i_kick, in, 1: watchdog clear.
- o_src_re, out, 1: ROM read enable.
- o_src_addr, out, AW: ROM word address.
- i_src_rdata, in, DATA_W: ROM data, valid exactly 1 cycle after o_src_re.
- o_tcm_valid, out, 1: TCM write request.
- o_tcm_addr, out, AW: TCM word address.
- o_tcm_wdata, out, DATA_W: TCM write data.
- i_tcm_ready, in, 1: TCM accepts the write when valid & ready.
- o_core_rstn, out, 1: active-low reset to the core.
- o_busy, out, 1: load in progress.
- o_done, out, 1: sticky; last load completed.
- o_timeout, out, 1: sticky; watchdog expired.
- o_cycle_cnt, out, CNT_W: current watchdog count.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all outputs 0 (o_core_rstn=0, core held); address counter and cycle counter 0.
- States: IDLE, READ, WRITE, ZFILL, RUN, TIMEOUT.
- IDLE: i_start -> latch N = min(i_load_words, DEPTH), clear o_done/o_timeout, o_busy=1. If N==0 go ZFILL (macro on) or RUN (macro off); otherwise go READ with addr=0.
- READ: o_src_re=1 for one cycle at o_src_addr=addr. Next cycle capture i_src_rdata into the data register, go WRITE.
- WRITE:
  - o_tcm_valid=1; addr and data are held stable until i_tcm_ready.
  - On handshake: addr+1. If addr+1==N, go ZFILL/RUN; else go READ.
  - Throughput is 1 word per 2 cycles with ready tied high; no write is ever dropped or duplicated.
- RUN entry: o_busy=0, o_done=1, o_core_rstn=1 from the first RUN cycle; cycle counter = 0.
- RUN watchdog:
  - Counter increments each cycle, saturating at all-ones.
  - i_kick clears it to 0; kick wins over a simultaneous increment or expiry.
  - When counter == TIMEOUT_CYCLES-1 and no kick: o_timeout=1, go TIMEOUT.
  - TIMEOUT_CYCLES==0: never expires.
- TIMEOUT: o_core_rstn = !HALT_ON_TIMEOUT; counter frozen.
- i_start handling:
  - In RUN or TIMEOUT: restart the load; o_core_rstn drops to 0 in the same cycle it is registered.
  - While o_busy: ignored.
- i_load_words > DEPTH: clamped to DEPTH; no address wrap.
- o_core_rstn is registered and glitch-free; it is never 1 while o_busy.

Optional Feature:
- ALTUSOC_LOADER_ZERO_FILL_EN defined: after the copy (or immediately if N==0), ZFILL writes 0 to addresses N..DEPTH-1 with the same valid/ready rule, then goes RUN. N==DEPTH skips ZFILL.
- Not defined: ZFILL state is absent; the copy goes straight to RUN and untouched TCM contents are left as-is.

Decomposition:
- Package altusoc_loader_pkg: state enum (IDLE..TIMEOUT) and the AW/clamp helper function.
- Sub-module altusoc_wdog_cnt: saturating counter with clear, enable and compare-to-limit expiry pulse; instantiated once.
- The FSM and datapath stay in altusoc_tcm_loader.

Test Plan:
- Basic copy: N=4, ROM[i]=32'hA000_0000+i, ready=1 -> TCM writes to addr 0..3 with those values in order; o_core_rstn rises 1 cycle after the 4th handshake; o_done=1.
- Backpressure: N=3, ready low 5 cycles on the 2nd write -> addr/wdata stable throughout the stall, exactly 3 writes total, data intact.
- Edge counts:
  - N=0 -> no writes (macro off), core released 1 cycle after start.
  - N=20000 with DEPTH=16384 -> exactly 16384 writes, last addr 16383.
- Watchdog: TIMEOUT_CYCLES=10, no kick -> o_timeout on the 10th RUN cycle, o_core_rstn=0. A kick every 8 cycles -> no timeout for 1000 cycles. Kick coincident with expiry -> no timeout.
- Reset mid-load: rstn low at word 7 of 16 -> outputs 0 immediately. A new start then copies all 16 words from addr 0.
- Zero fill (macro on): DEPTH=16, N=5 -> 5 ROM writes followed by 11 zero writes to addr 5..15, then RUN.

Source files
------------

// File: rtl/altusoc_loader_pkg.sv
// ---------------------------------------------------------------------------
// altusoc_loader_pkg
// Shared definitions for the AltuSOC TCM boot loader:
//   - state_t     : loader/watchdog FSM states
//   - addr_width  : TCM word-address width for a given depth
//   - clamp_words : limits a requested word count to the TCM depth
// ---------------------------------------------------------------------------
package altusoc_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ZFILL,
    ST_RUN,
    ST_TIMEOUT
  } state_t;

  // At least one address bit, even for a one- or two-word TCM.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [31:0] clamp_words(input logic [31:0] words,
                                              input logic [31:0] depth);
    return (words > depth) ? depth : words;
  endfunction

endpackage

// File: rtl/altusoc_wdog_cnt.sv
// ---------------------------------------------------------------------------
// altusoc_wdog_cnt
// Saturating up-counter with synchronous clear and count enable. Raises a
// combinational expiry pulse while the count sits at LIMIT-1, counting is
// enabled and no clear is requested, so a clear always wins over expiry.
// LIMIT == 0 disables expiry.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : clear count to zero (highest priority)
//   en        : increment enable (saturates at all-ones)
//   cnt       : current count
//   expire    : expiry pulse
// ---------------------------------------------------------------------------
module altusoc_wdog_cnt #(
  parameter int          CNT_W = 32,
  parameter int unsigned LIMIT = 100000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  // Wraps when LIMIT == 0; the expiry term below masks that case.
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);
  localparam bit               LIMIT_ON = (LIMIT != 0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = LIMIT_ON && en && !clr && (cnt == LIMIT_M1);

endmodule

// File: rtl/altusoc_tcm_loader.sv
// ---------------------------------------------------------------------------
// altusoc_tcm_loader
// Boot-image loader and run watchdog. On i_start it copies N words
// (N = min(i_load_words, DEPTH)) from a synchronous boot ROM into the TCM
// write port while holding the core in reset, then releases the core and
// runs a cycle watchdog that flags a hang.
//
// Build option: ALTUSOC_LOADER_ZERO_FILL_EN -- when defined, TCM words
// N..DEPTH-1 are written with zero after the copy, before release.
//
// Ports:
//   clk, rstn              : clock, asynchronous active-low reset
//   i_start, i_load_words  : load request and requested word count
//   i_kick                 : watchdog clear
//   o_src_re, o_src_addr   : ROM read enable / word address
//   i_src_rdata            : ROM data, valid one cycle after o_src_re
//   o_tcm_valid/addr/wdata : TCM write request, held until i_tcm_ready
//   i_tcm_ready            : TCM write accept
//   o_core_rstn            : registered active-low core reset
//   o_busy, o_done         : load in progress / last load completed (sticky)
//   o_timeout              : watchdog expired (sticky)
//   o_cycle_cnt            : current watchdog count
// ---------------------------------------------------------------------------
module altusoc_tcm_loader
  import altusoc_loader_pkg::*;
#(
  parameter int          DATA_W          = 32,
  parameter int          DEPTH           = 16384,
  parameter int          CNT_W           = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter bit          HALT_ON_TIMEOUT = 1'b1,
  localparam int         AW              = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic [AW:0]       i_load_words,
  input  logic              i_kick,
  output logic              o_src_re,
  output logic [AW-1:0]     o_src_addr,
  input  logic [DATA_W-1:0] i_src_rdata,
  output logic              o_tcm_valid,
  output logic [AW-1:0]     o_tcm_addr,
  output logic [DATA_W-1:0] o_tcm_wdata,
  input  logic              i_tcm_ready,
  output logic              o_core_rstn,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_cycle_cnt
);

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  state_t            state;
  // One bit wider than the TCM address so a full-depth copy ends without wrap.
  logic [AW:0]       addr;
  logic [AW:0]       n_words;
  logic [AW:0]       addr_inc;
  logic [AW:0]       load_n;
  logic [DATA_W-1:0] data_q;
  logic              fresh;
  logic              start_acc;
  logic              hs;
  logic              wd_clr;
  logic              wd_en;
  logic              wd_expire;

  assign load_n    = (AW+1)'(clamp_words(32'(i_load_words), 32'(DEPTH)));
  assign addr_inc  = addr + ONE;
  assign hs        = o_tcm_valid && i_tcm_ready;
  assign start_acc = i_start &&
                     ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_TIMEOUT));

  // Counter is held at zero outside RUN/TIMEOUT so it enters RUN at 0;
  // a restart also clears it so a zero-length reload begins counting fresh.
  assign wd_en  = (state == ST_RUN);
  assign wd_clr = ((state != ST_RUN) && (state != ST_TIMEOUT)) || start_acc ||
                  ((state == ST_RUN) && i_kick);

  altusoc_wdog_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (wd_clr),
    .en     (wd_en),
    .cnt    (o_cycle_cnt),
    .expire (wd_expire)
  );

  assign o_src_addr = addr[AW-1:0];
  assign o_tcm_addr = addr[AW-1:0];
  // ROM data arrives during the first WRITE cycle; forward it that cycle and
  // serve the captured copy for any stall cycles after it.
  assign o_tcm_wdata = fresh ? i_src_rdata : data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      addr        <= '0;
      n_words     <= '0;
      data_q      <= '0;
      fresh       <= 1'b0;
      o_src_re    <= 1'b0;
      o_tcm_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
      o_core_rstn <= 1'b0;
    end else begin
      o_src_re <= 1'b0;
      fresh    <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN, ST_TIMEOUT: begin
          if (start_acc) begin
            n_words     <= load_n;
            addr        <= '0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_busy      <= 1'b1;
            o_core_rstn <= 1'b0;
            if (load_n == '0) begin
`ifdef ALTUSOC_LOADER_ZERO_FILL_EN
              state       <= ST_ZFILL;
              o_tcm_valid <= 1'b1;
              data_q      <= '0;
`else
              state       <= ST_RUN;
              o_busy      <= 1'b0;
              o_done      <= 1'b1;
              o_core_rstn <= 1'b1;
`endif
            end else begin
              state    <= ST_READ;
              o_src_re <= 1'b1;
            end
          end else if (wd_expire) begin
            state       <= ST_TIMEOUT;
            o_timeout   <= 1'b1;
            o_core_rstn <= !HALT_ON_TIMEOUT;
          end
        end

        ST_READ: begin
          state       <= ST_WRITE;
          o_tcm_valid <= 1'b1;
          fresh       <= 1'b1;
        end

        ST_WRITE: begin
          if (fresh) begin
            data_q <= i_src_rdata;
          end
          if (hs) begin
            o_tcm_valid <= 1'b0;
            addr        <= addr_inc;
            if (addr_inc == n_words) begin
`ifdef ALTUSOC_LOADER_ZERO_FILL_EN
              if (addr_inc == DEPTH_N) begin
                state       <= ST_RUN;
                o_busy      <= 1'b0;
                o_done      <= 1'b1;
                o_core_rstn <= 1'b1;
              end else begin
                state       <= ST_ZFILL;
                o_tcm_valid <= 1'b1;
                data_q      <= '0;
              end
`else
              state       <= ST_RUN;
              o_busy      <= 1'b0;
              o_done      <= 1'b1;
              o_core_rstn <= 1'b1;
`endif
            end else begin
              state    <= ST_READ;
              o_src_re <= 1'b1;
            end
          end
        end

`ifdef ALTUSOC_LOADER_ZERO_FILL_EN
        ST_ZFILL: begin
          if (hs) begin
            addr <= addr_inc;
            if (addr_inc == DEPTH_N) begin
              state       <= ST_RUN;
              o_tcm_valid <= 1'b0;
              o_busy      <= 1'b0;
              o_done      <= 1'b1;
              o_core_rstn <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state       <= ST_IDLE;
          o_tcm_valid <= 1'b0;
          o_busy      <= 1'b0;
          o_core_rstn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_altusoc_tcm_loader.sv
// ---------------------------------------------------------------------------
// tb_altusoc_tcm_loader
// Directed and randomized checks of the TCM loader against a word-list
// reference model (expected TCM write sequence built from the ROM image).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_altusoc_tcm_loader;

`ifdef ALTUSOC_LOADER_ZERO_FILL_EN
  localparam int DEPTH = 64;
`else
  localparam int DEPTH = 16384;
`endif
  localparam int AW     = $clog2(DEPTH);
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int TOUT   = 10;
  localparam int BIG    = (20000 < 2*DEPTH) ? 20000 : 2*DEPTH - 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [AW:0]       load_words;
  logic              kick;
  logic              src_re;
  logic [AW-1:0]     src_addr;
  logic [DATA_W-1:0] src_rdata = '0;
  logic              tcm_valid;
  logic [AW-1:0]     tcm_addr;
  logic [DATA_W-1:0] tcm_wdata;
  logic              tcm_ready;
  logic              core_rstn;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_cnt;

  altusoc_tcm_loader #(
    .DATA_W          (DATA_W),
    .DEPTH           (DEPTH),
    .CNT_W           (CNT_W),
    .TIMEOUT_CYCLES  (TOUT),
    .HALT_ON_TIMEOUT (1'b1)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (start),
    .i_load_words (load_words),
    .i_kick       (kick),
    .o_src_re     (src_re),
    .o_src_addr   (src_addr),
    .i_src_rdata  (src_rdata),
    .o_tcm_valid  (tcm_valid),
    .o_tcm_addr   (tcm_addr),
    .o_tcm_wdata  (tcm_wdata),
    .i_tcm_ready  (tcm_ready),
    .o_core_rstn  (core_rstn),
    .o_busy       (busy),
    .o_done       (done),
    .o_timeout    (timeout),
    .o_cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Boot ROM: data is valid only in the cycle after a read; garbage otherwise.
  logic [DATA_W-1:0] rom [DEPTH];
  always @(posedge clk) src_rdata <= src_re ? rom[src_addr] : $urandom();

  // Write monitor and protocol watchers.
  int unsigned   cyc = 0;
  logic [AW-1:0] wq_addr [$];
  logic [31:0]   wq_data [$];
  int            last_hs_cyc = 0;
  int            stall_err = 0;
  int            busy_err = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (tcm_valid && tcm_ready) begin
        wq_addr.push_back(tcm_addr);
        wq_data.push_back(tcm_wdata);
        last_hs_cyc = int'(cyc);
      end
      if (prev_stall && (!tcm_valid || tcm_addr !== prev_addr || tcm_wdata !== prev_data))
        stall_err++;
      if (core_rstn && busy) busy_err++;
      prev_stall = tcm_valid && !tcm_ready;
      prev_addr  = tcm_addr;
      prev_data  = tcm_wdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;
  int rmode  = 0;   // 0: ready high, 1: random ready, 2: driven by the test

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic nxt();
    @(posedge clk);
    #1;
    if (rmode == 0) tcm_ready = 1'b1;
    else if (rmode == 1) tcm_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference: word i of the copy goes to address i with rom[i]; with zero
  // fill the remaining addresses up to DEPTH-1 receive zero.
  task automatic verify_writes(input int base, input int ncopy, input string tag);
    int nw, exp_n, bad;
    logic [31:0] ed;
    exp_n = ncopy;
`ifdef ALTUSOC_LOADER_ZERO_FILL_EN
    exp_n = DEPTH;
`endif
    nw  = wq_addr.size() - base;
    bad = 0;
    for (int i = 0; i < exp_n && i < nw; i++) begin
      ed = (i < ncopy) ? rom[i] : 32'h0;
      if (wq_addr[base+i] !== AW'(i) || wq_data[base+i] !== ed) bad++;
    end
    check({tag, "_count"}, nw, exp_n);
    check({tag, "_data"}, bad, 0);
  endtask

  task automatic wait_release(input int budget, output int rel, output bit ok);
    ok  = 1'b0;
    rel = 0;
    for (int k = 0; k < budget; k++) begin
      if (core_rstn && !busy) begin
        ok  = 1'b1;
        rel = int'(cyc);
        break;
      end
      nxt();
    end
  endtask

  task automatic do_load(input int n, input int mode, input string tag);
    int ncopy, nexp, base, sc, rel, budget;
    bit ok;
    ncopy = (n > DEPTH) ? DEPTH : n;
    nexp  = ncopy;
`ifdef ALTUSOC_LOADER_ZERO_FILL_EN
    nexp = DEPTH;
`endif
    budget = (mode == 0) ? 3*nexp + 50 : 8*nexp + 50;
    base   = wq_addr.size();
    rmode  = mode;
    load_words = (AW+1)'(n);
    start = 1'b1;
    sc    = int'(cyc);
    nxt();
    start = 1'b0;
    wait_release(budget, rel, ok);
    check({tag, "_released"}, ok, 1'b1);
    check({tag, "_rel_cycle"}, rel, (nexp == 0) ? sc + 1 : last_hs_cyc + 1);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_cnt0"}, cycle_cnt, 0);
    verify_writes(base, ncopy, tag);
  endtask

  task automatic count_run(output int n);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      nxt();
      if (core_rstn && !timeout) n++;
      else break;
    end
  endtask

  initial begin
    int base, rel, runs, n;
    bit ok;
    rstn = 1'b0; start = 1'b0; load_words = '0; kick = 1'b0; tcm_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom();
    repeat (3) nxt();

    // Reset state
    check("rst_core_rstn", core_rstn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_valid", tcm_valid, 1'b0);
    check("rst_src_re", src_re, 1'b0);
    check("rst_cnt", cycle_cnt, 0);
    rstn = 1'b1;
    repeat (2) nxt();
    check("idle_core_held", core_rstn, 1'b0);

    // Basic copy
    for (int i = 0; i < 4; i++) rom[i] = 32'hA000_0000 + i;
    do_load(4, 0, "basic");

    // Watchdog: no kick -> exactly TOUT RUN cycles, then halt
    count_run(runs);
    check("wd_run_cycles", runs, TOUT);
    check("wd_timeout", timeout, 1'b1);
    check("wd_core_halt", core_rstn, 1'b0);
    check("wd_done_sticky", done, 1'b1);
    repeat (3) nxt();
    check("wd_cnt_frozen", cycle_cnt, TOUT);

    // Backpressure: ready low 5 cycles on the 2nd write
    for (int i = 0; i < 3; i++) rom[i] = $urandom();
    rmode = 2; tcm_ready = 1'b1;
    base = wq_addr.size();
    load_words = (AW+1)'(3);
    start = 1'b1;
    nxt();
    start = 1'b0;
    for (int k = 0; k < 20 && wq_addr.size() - base < 1; k++) nxt();
    tcm_ready = 1'b0;
    repeat (6) nxt();
    check("bp_stall_valid", tcm_valid, 1'b1);
    check("bp_stall_addr", tcm_addr, 1);
    check("bp_stall_data", tcm_wdata, rom[1]);
    tcm_ready = 1'b1;
    wait_release(100, rel, ok);
    check("bp_released", ok, 1'b1);
    verify_writes(base, 3, "bp");
    check("bp_stable", stall_err, 0);

    // N = 0
    do_load(0, 0, "zero");

    // Clamp above DEPTH
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom();
    do_load(BIG, 0, "clamp");
    check("clamp_last_addr", wq_addr[wq_addr.size()-1], DEPTH - 1);

    // Kick every 8 cycles keeps the core running
    do_load(2, 0, "kick_load");
    for (int i = 0; i < 1000; i++) begin
      kick = (i % 8 == 7);
      nxt();
    end
    kick = 1'b0;
    check("kick_no_timeout", timeout, 1'b0);
    check("kick_core_run", core_rstn, 1'b1);

    // Kick coincident with expiry
    do_load(2, 0, "coinc_load");
    repeat (TOUT - 1) nxt();
    check("coinc_cnt_at_limit", cycle_cnt, TOUT - 1);
    kick = 1'b1;
    nxt();
    kick = 1'b0;
    check("coinc_no_timeout", timeout, 1'b0);
    check("coinc_cnt_cleared", cycle_cnt, 0);
    check("coinc_core_run", core_rstn, 1'b1);
    count_run(runs);
    check("coinc_rerun_cycles", runs, TOUT);

    // Randomized loads with random backpressure
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < DEPTH && i < 64; i++) rom[i] = $urandom();
      n = int'($urandom_range(1, (DEPTH < 40) ? DEPTH : 40));
      do_load(n, 1, $sformatf("rnd%0d", t));
    end

    // Reset mid-load
    for (int i = 0; i < 16; i++) rom[i] = $urandom();
    rmode = 0;
    base = wq_addr.size();
    load_words = (AW+1)'(16);
    start = 1'b1;
    nxt();
    start = 1'b0;
    for (int k = 0; k < 100 && wq_addr.size() - base < 7; k++) nxt();
    rstn = 1'b0;
    #2;
    check("mrst_core_rstn", core_rstn, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_valid", tcm_valid, 1'b0);
    check("mrst_src_re", src_re, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_addr", tcm_addr, 0);
    check("mrst_cnt", cycle_cnt, 0);
    repeat (2) nxt();
    rstn = 1'b1;
    nxt();
    do_load(16, 0, "after_rst");

    check("never_busy_released", busy_err, 0);
    check("stall_stable_all", stall_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
